// File: rtl/kf8255_seq_pkg.sv
// Shared types and constants for the KF8255 bus sequencer: FSM state
// encoding, PPI register addresses and small helper functions.
package kf8255_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    RECOVER = 3'd3,
    ACK     = 3'd4
  } seq_state_t;

  // PPI register addresses, matching the existing KF8255 definitions.
  localparam logic [1:0] PORT_A  = 2'd0;
  localparam logic [1:0] PORT_B  = 2'd1;
  localparam logic [1:0] PORT_C  = 2'd2;
  localparam logic [1:0] CONTROL = 2'd3;

  // True while the PPI bus is owned (chip select asserted).
  function automatic logic bus_phase(input seq_state_t s);
    logic result;
    case (s)
      SETUP:   result = 1'b1;
      STROBE:  result = 1'b1;
      RECOVER: result = 1'b1;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

  // Largest of three phase lengths, used to size the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/kf8255_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or
// after the pointer, wrapping around. The pointer itself lives in the caller.
module kf8255_rr_arbiter
  import kf8255_seq_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_index,
  output logic               grant_valid
);

  localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] cand;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, pointer} + (IDX_W+1)'(off);
      if (cand >= NUM_W) begin
        cand = cand - NUM_W;
      end else begin
        cand = cand;
      end
      if (!grant_valid && req[cand[IDX_W-1:0]]) begin
        grant_valid                    = 1'b1;
        grant_index                    = cand[IDX_W-1:0];
        grant[cand[IDX_W-1:0]]         = 1'b1;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/kf8255_bus_sequencer.sv
// Shares one KF8255 PPI bus between several requesters. Arbitrates
// round-robin, latches the winning command and plays it out with fixed
// setup / strobe / recovery timing, then acks the requester for one cycle.
module kf8255_bus_sequencer
  import kf8255_seq_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int SETUP_CYCLES    = 1,
  parameter int STROBE_CYCLES   = 2,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [2*NUM_REQ-1:0] req_address,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic                 ppi_chip_select_n,
  output logic                 ppi_read_enable_n,
  output logic                 ppi_write_enable_n,
  output logic [1:0]           ppi_address,
  output logic [7:0]           ppi_data_out,
  input  logic [7:0]           ppi_data_in
);

  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_PHASE = max3(SETUP_CYCLES, STROBE_CYCLES, RECOVERY_CYCLES);
  localparam int CNT_W     = $clog2(MAX_PHASE) + 1;

  // Each phase loads length-1 and runs down to zero.
  localparam logic [CNT_W-1:0] SETUP_LOAD    = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD   = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOVERY_LOAD = CNT_W'(RECOVERY_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NUM_REQ - 1);

  seq_state_t         state;
  seq_state_t         state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               load_cmd;

  logic [IDX_W-1:0]   pointer;
  logic [IDX_W-1:0]   pointer_next;
  logic [IDX_W-1:0]   grant_index;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               cmd_write;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_index;
  logic               arb_valid;

  logic               sel_write;
  logic [1:0]         sel_address;
  logic [7:0]         sel_wdata;

  kf8255_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arbiter (
    .req         (req),
    .pointer     (pointer),
    .grant       (arb_grant),
    .grant_index (arb_index),
    .grant_valid (arb_valid)
  );

  // Select the command fields of the requester the arbiter is offering.
  always_comb begin
    sel_write   = 1'b0;
    sel_address = 2'b00;
    sel_wdata   = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_write   = req_write[i];
        sel_address = req_address[2*i +: 2];
        sel_wdata   = req_wdata[8*i +: 8];
      end else begin
        sel_write = sel_write;
      end
    end
  end

  // Rotate the pointer to just past the requester being acked.
  always_comb begin
    if (grant_index == LAST_IDX) begin
      pointer_next = '0;
    end else begin
      pointer_next = grant_index + IDX_W'(1);
    end
  end

  // Next-state and phase counter logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_cmd   = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          state_next = SETUP;
          cnt_next   = SETUP_LOAD;
          load_cmd   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_next = STROBE;
          cnt_next   = STROBE_LOAD;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          state_next = RECOVER;
          cnt_next   = RECOVERY_LOAD;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RECOVER: begin
        if (cnt == '0) begin
          state_next = ACK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ACK: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM state and phase counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Latch the granted command and advance the round-robin pointer on ack.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd_write    <= 1'b0;
      grant_index  <= '0;
      grant_onehot <= '0;
      pointer      <= '0;
    end else begin
      if (load_cmd) begin
        cmd_write    <= sel_write;
        grant_index  <= arb_index;
        grant_onehot <= arb_grant;
      end
      if (state == ACK) begin
        pointer <= pointer_next;
      end
    end
  end

  // Registered bus outputs decoded from the upcoming state, so strobes
  // change cleanly on the clock edge; WR# rises one phase before CS#.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ppi_chip_select_n  <= 1'b1;
      ppi_read_enable_n  <= 1'b1;
      ppi_write_enable_n <= 1'b1;
      ppi_address        <= 2'b00;
      ppi_data_out       <= 8'h00;
      ack                <= '0;
      rdata              <= 8'h00;
      busy               <= 1'b0;
    end else begin
      ppi_chip_select_n  <= ~bus_phase(state_next);
      busy               <= bus_phase(state_next);
      ppi_write_enable_n <= ~((state_next == STROBE) && cmd_write);
      ppi_read_enable_n  <= ~((state_next == STROBE) && !cmd_write);
      ack                <= (state_next == ACK) ? grant_onehot : '0;
      if (load_cmd) begin
        ppi_address  <= sel_address;
        ppi_data_out <= sel_write ? sel_wdata : 8'h00;
      end
      if ((state == STROBE) && (cnt == '0) && !cmd_write) begin
        rdata <= ppi_data_in;
      end
    end
  end

endmodule

// File: tb/tb_kf8255_bus_sequencer.sv
// Directed bench for kf8255_bus_sequencer with a simple PPI model and an
// ack scoreboard. A second instance exercises non-default phase lengths.
module tb_kf8255_bus_sequencer;
  import kf8255_seq_pkg::*;

  logic        clock;
  logic        reset_n;
  logic [1:0]  req;
  logic [1:0]  req_write;
  logic [3:0]  req_address;
  logic [15:0] req_wdata;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic        busy;
  logic        cs_n;
  logic        rd_n;
  logic        wr_n;
  logic [1:0]  ppi_addr;
  logic [7:0]  ppi_dout;
  logic [7:0]  ppi_din;

  logic [1:0]  req6;
  logic [1:0]  req_write6;
  logic [3:0]  req_address6;
  logic [15:0] req_wdata6;
  logic [1:0]  ack6;
  logic [7:0]  rdata6;
  logic        busy6;
  logic        cs6_n;
  logic        rd6_n;
  logic        wr6_n;
  logic [1:0]  addr6;
  logic [7:0]  dout6;
  logic [7:0]  din6;

  logic [7:0]  port_in [4];
  logic [7:0]  latched [4];

  typedef struct packed {
    logic [1:0] ack;
    logic       is_read;
    logic [7:0] rdata;
  } exp_t;
  exp_t sb[$];

  int checks;
  int errors;

  kf8255_bus_sequencer dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .req                (req),
    .req_write          (req_write),
    .req_address        (req_address),
    .req_wdata          (req_wdata),
    .ack                (ack),
    .rdata              (rdata),
    .busy               (busy),
    .ppi_chip_select_n  (cs_n),
    .ppi_read_enable_n  (rd_n),
    .ppi_write_enable_n (wr_n),
    .ppi_address        (ppi_addr),
    .ppi_data_out       (ppi_dout),
    .ppi_data_in        (ppi_din)
  );

  kf8255_bus_sequencer #(
    .NUM_REQ         (2),
    .SETUP_CYCLES    (2),
    .STROBE_CYCLES   (4),
    .RECOVERY_CYCLES (1)
  ) dut6 (
    .clock              (clock),
    .reset_n            (reset_n),
    .req                (req6),
    .req_write          (req_write6),
    .req_address        (req_address6),
    .req_wdata          (req_wdata6),
    .ack                (ack6),
    .rdata              (rdata6),
    .busy               (busy6),
    .ppi_chip_select_n  (cs6_n),
    .ppi_read_enable_n  (rd6_n),
    .ppi_write_enable_n (wr6_n),
    .ppi_address        (addr6),
    .ppi_data_out       (dout6),
    .ppi_data_in        (din6)
  );

  assign ppi_din = port_in[ppi_addr];
  assign din6    = 8'h00;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // PPI model: a write lands on the rising edge of WR# while CS# is low.
  always @(posedge wr_n) begin
    if (cs_n === 1'b0) begin
      latched[ppi_addr] <= ppi_dout;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic wait_ack(input string tag, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (ack !== 2'b00) begin
        got = 1'b1;
      end
    end
    check(tag, 32'(got), 32'd1);
  endtask

  // Scoreboard: every ack pulse must match the oldest expected transaction.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && ack !== 2'b00) begin
      if (sb.size() == 0) begin
        check("spurious_ack", 32'(ack), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_ack", 32'(ack), 32'(e.ack));
        if (e.is_read) begin
          check("sb_rdata", 32'(rdata), 32'(e.rdata));
        end
      end
    end
  end

  initial begin
    checks       = 0;
    errors       = 0;
    reset_n      = 1'b0;
    req          = 2'b00;
    req_write    = 2'b00;
    req_address  = 4'h0;
    req_wdata    = 16'h0000;
    req6         = 2'b00;
    req_write6   = 2'b00;
    req_address6 = 4'h0;
    req_wdata6   = 16'h0000;
    port_in[0]   = 8'hA0;
    port_in[1]   = 8'h5A;
    port_in[2]   = 8'hC2;
    port_in[3]   = 8'hFF;
    step();
    step();
    reset_n = 1'b1;
    step();

    // Reset state
    check("rst_cs", 32'(cs_n), 32'd1);
    check("rst_rd", 32'(rd_n), 32'd1);
    check("rst_wr", 32'(wr_n), 32'd1);
    check("rst_addr", 32'(ppi_addr), 32'd0);
    check("rst_dout", 32'(ppi_dout), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // 1: single write of control word 8'h82
    req[0] = 1'b1; req_write[0] = 1'b1;
    req_address[1:0] = CONTROL; req_wdata[7:0] = 8'h82;
    sb.push_back('{ack: 2'b01, is_read: 1'b0, rdata: 8'h00});
    for (int c = 1; c <= 6; c++) begin
      step();
      check("t1_cs", 32'(cs_n), (c <= 4) ? 32'd0 : 32'd1);
      check("t1_wr", 32'(wr_n), (c == 2 || c == 3) ? 32'd0 : 32'd1);
      check("t1_rd", 32'(rd_n), 32'd1);
      check("t1_ack", 32'(ack), (c == 5) ? 32'd1 : 32'd0);
      check("t1_busy", 32'(busy), (c <= 4) ? 32'd1 : 32'd0);
      if (c <= 4) begin
        check("t1_addr", 32'(ppi_addr), 32'd3);
        check("t1_dout", 32'(ppi_dout), 32'h82);
      end
      if (c == 1) req[0] = 1'b0;
    end
    check("t1_ppi_ctrl", 32'(latched[3]), 32'h82);

    // 2: single read from port B
    req[1] = 1'b1; req_write[1] = 1'b0; req_address[3:2] = PORT_B;
    sb.push_back('{ack: 2'b10, is_read: 1'b1, rdata: 8'h5A});
    for (int c = 1; c <= 5; c++) begin
      step();
      check("t2_rd", 32'(rd_n), (c == 2 || c == 3) ? 32'd0 : 32'd1);
      check("t2_wr", 32'(wr_n), 32'd1);
      check("t2_ack", 32'(ack), (c == 5) ? 32'd2 : 32'd0);
      if (c == 5) check("t2_rdata", 32'(rdata), 32'h5A);
      if (c == 1) req[1] = 1'b0;
    end

    // 3: contention, both held; grants alternate 0,1,0,1 with one idle cycle
    req_write = 2'b11;
    req_address = {2'd1, PORT_A};
    req_wdata = 16'h2211;
    req = 2'b11;
    sb.push_back('{ack: 2'b01, is_read: 1'b0, rdata: 8'h00});
    sb.push_back('{ack: 2'b10, is_read: 1'b0, rdata: 8'h00});
    sb.push_back('{ack: 2'b01, is_read: 1'b0, rdata: 8'h00});
    sb.push_back('{ack: 2'b10, is_read: 1'b0, rdata: 8'h00});
    for (int k = 0; k < 4; k++) begin
      wait_ack("t3_ack_timeout", 12);
      check("t3_addr", 32'(ppi_addr), 32'(k % 2));
      if (k == 3) req = 2'b00;
      step();
      check("t3_idle_busy", 32'(busy), 32'd0);
      check("t3_idle_cs", 32'(cs_n), 32'd1);
      step();
      check("t3_regrant_cs", 32'(cs_n), (k < 3) ? 32'd0 : 32'd1);
    end
    check("t3_rdata_held", 32'(rdata), 32'h5A);

    // 4: address change and req drop after grant are ignored
    req_write[0] = 1'b1; req_address[1:0] = PORT_B; req_wdata[7:0] = 8'h33;
    req[0] = 1'b1;
    sb.push_back('{ack: 2'b01, is_read: 1'b0, rdata: 8'h00});
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c <= 4) check("t4_addr", 32'(ppi_addr), 32'd1);
      check("t4_ack", 32'(ack), (c == 5) ? 32'd1 : 32'd0);
      if (c == 2) begin
        req_address[1:0] = PORT_C;
        req[0] = 1'b0;
      end
    end
    for (int c = 0; c < 3; c++) begin
      step();
      check("t4_no_repeat", 32'(cs_n), 32'd1);
    end

    // 5: reset asserted mid-strobe
    req_write[1] = 1'b1; req_address[3:2] = PORT_C; req_wdata[15:8] = 8'h44;
    req[1] = 1'b1;
    step();
    step();
    check("t5_wr_low", 32'(wr_n), 32'd0);
    reset_n = 1'b0;
    req[1] = 1'b0;
    #1;
    check("t5_wr_rel", 32'(wr_n), 32'd1);
    check("t5_cs_rel", 32'(cs_n), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ack", 32'(ack), 32'd0);
    step();
    reset_n = 1'b1;
    req = 2'b11;
    sb.push_back('{ack: 2'b01, is_read: 1'b0, rdata: 8'h00});
    sb.push_back('{ack: 2'b10, is_read: 1'b0, rdata: 8'h00});
    wait_ack("t5_ack0_timeout", 12);
    check("t5_first_grant", 32'(ack), 32'd1);
    wait_ack("t5_ack1_timeout", 12);
    req = 2'b00;
    step();
    step();

    // 6: SETUP=2, STROBE=4 instance
    req_write6[0] = 1'b1; req_address6[1:0] = CONTROL; req_wdata6[7:0] = 8'hC3;
    req6[0] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      check("t6_wr", 32'(wr6_n), (c >= 3 && c <= 6) ? 32'd0 : 32'd1);
      check("t6_cs", 32'(cs6_n), (c <= 7) ? 32'd0 : 32'd1);
      check("t6_ack", 32'(ack6), (c == 8) ? 32'd1 : 32'd0);
      check("t6_busy", 32'(busy6), (c <= 7) ? 32'd1 : 32'd0);
      if (c == 1) req6[0] = 1'b0;
    end
    check("t6_dout", 32'(dout6), 32'hC3);

    step();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit in case a wait never resolves.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
